// File: rtl/tmr_vtimer_sched.sv
`default_nettype none
// ============================================================================
// tmr_vtimer_sched : one-shot virtual timers multiplexed on a shared timebase
// Rev 1.0
// ============================================================================
module tmr_vtimer_sched #(
  parameter  int CH_NUM    = 4,
  parameter  int CNT_WIDTH = 32,
  localparam int CH_IDX_W  = $clog2(CH_NUM)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tick_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_op_i,
  input  logic [CH_IDX_W-1:0]  req_ch_i,
  input  logic [CNT_WIDTH-1:0] req_delta_i,
  output logic [CNT_WIDTH-1:0] now_o,
  output logic [CH_NUM-1:0]    active_o,
  output logic                 fire_valid_o,
  output logic [CH_IDX_W-1:0]  fire_ch_o,
  input  logic                 fire_ready_i,
  output logic                 next_valid_o,
  output logic [CH_IDX_W-1:0]  next_ch_o,
  output logic [CNT_WIDTH-1:0] next_rem_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_FIRE = 2'd2
  } state_t;

  localparam logic [CH_IDX_W-1:0]  LAST_IDX  = CH_IDX_W'(CH_NUM - 1);
  localparam logic [CNT_WIDTH-1:0] DELTA_MAX = {1'b0, {(CNT_WIDTH-1){1'b1}}};
  localparam logic [CH_IDX_W:0]    CH_LIMIT  = (CH_IDX_W+1)'(CH_NUM);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] now_q, now_d;
  logic [CH_NUM-1:0]    active_q, active_d;
  logic [CNT_WIDTH-1:0] deadline_q [CH_NUM];
  logic [CNT_WIDTH-1:0] deadline_d [CH_NUM];
  logic [CH_IDX_W-1:0]  idx_q, idx_d;
  logic                 pend_q, pend_d;
  logic                 exp_found_q, exp_found_d;
  logic [CH_IDX_W-1:0]  exp_ch_q, exp_ch_d;
  logic                 min_found_q, min_found_d;
  logic [CH_IDX_W-1:0]  min_ch_q, min_ch_d;
  logic [CNT_WIDTH-1:0] min_rem_q, min_rem_d;
  logic                 fire_valid_q, fire_valid_d;
  logic [CH_IDX_W-1:0]  fire_ch_q, fire_ch_d;
  logic                 next_valid_q, next_valid_d;
  logic [CH_IDX_W-1:0]  next_ch_q, next_ch_d;
  logic [CNT_WIDTH-1:0] next_rem_q, next_rem_d;

  logic                 cur_act, cur_exp;
  logic [CNT_WIDTH-1:0] cur_rem;
  logic                 scan_exp_found, scan_min_found;
  logic [CH_IDX_W-1:0]  scan_exp_ch, scan_min_ch;
  logic [CNT_WIDTH-1:0] scan_min_rem;
  logic [CNT_WIDTH-1:0] arm_delta;
  logic                 req_ch_ok;
  logic                 go_scan;

  // Wrap-safe expiry: a deadline at or behind now gives rem of zero or MSB set.
  always_comb begin
    cur_act = active_q[idx_q];
    cur_rem = deadline_q[idx_q] - now_q;
    cur_exp = (cur_rem == '0) || cur_rem[CNT_WIDTH-1];

    scan_exp_found = exp_found_q;
    scan_exp_ch    = exp_ch_q;
    if (cur_act && cur_exp && !exp_found_q) begin
      scan_exp_found = 1'b1;
      scan_exp_ch    = idx_q;
    end

    scan_min_found = min_found_q;
    scan_min_ch    = min_ch_q;
    scan_min_rem   = min_rem_q;
    if (cur_act && !cur_exp && (!min_found_q || (cur_rem < min_rem_q))) begin
      scan_min_found = 1'b1;
      scan_min_ch    = idx_q;
      scan_min_rem   = cur_rem;
    end

    arm_delta = req_delta_i[CNT_WIDTH-1] ? DELTA_MAX : req_delta_i;
    req_ch_ok = ({1'b0, req_ch_i} < CH_LIMIT);
  end

  always_comb begin
    state_d      = state_q;
    now_d        = tick_i ? (now_q + CNT_WIDTH'(1)) : now_q;
    active_d     = active_q;
    deadline_d   = deadline_q;
    idx_d        = idx_q;
    pend_d       = pend_q;
    exp_found_d  = exp_found_q;
    exp_ch_d     = exp_ch_q;
    min_found_d  = min_found_q;
    min_ch_d     = min_ch_q;
    min_rem_d    = min_rem_q;
    fire_valid_d = fire_valid_q;
    fire_ch_d    = fire_ch_q;
    next_valid_d = next_valid_q;
    next_ch_d    = next_ch_q;
    next_rem_d   = next_rem_q;
    go_scan      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          if (req_ch_ok) begin
            if (req_op_i) begin
              active_d[req_ch_i] = 1'b0;
            end else begin
              active_d[req_ch_i]   = 1'b1;
              deadline_d[req_ch_i] = now_q + arm_delta;
            end
          end
          go_scan = 1'b1;
        end else if (tick_i) begin
          go_scan = 1'b1;
        end
      end

      ST_SCAN: begin
        exp_found_d = scan_exp_found;
        exp_ch_d    = scan_exp_ch;
        min_found_d = scan_min_found;
        min_ch_d    = scan_min_ch;
        min_rem_d   = scan_min_rem;
        if (idx_q == LAST_IDX) begin
          next_valid_d = scan_min_found;
          next_ch_d    = scan_min_ch;
          next_rem_d   = scan_min_rem;
          if (scan_exp_found) begin
            state_d      = ST_FIRE;
            fire_valid_d = 1'b1;
            fire_ch_d    = scan_exp_ch;
          end else if (pend_q || tick_i) begin
            go_scan = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          idx_d  = idx_q + CH_IDX_W'(1);
          pend_d = pend_q | tick_i;
        end
      end

      ST_FIRE: begin
        if (fire_ready_i) begin
          active_d[fire_ch_q] = 1'b0;
          fire_valid_d        = 1'b0;
          go_scan             = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Every scan pass starts from channel 0 with empty accumulators.
    if (go_scan) begin
      state_d     = ST_SCAN;
      idx_d       = '0;
      pend_d      = 1'b0;
      exp_found_d = 1'b0;
      exp_ch_d    = '0;
      min_found_d = 1'b0;
      min_ch_d    = '0;
      min_rem_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      now_q        <= '0;
      active_q     <= '0;
      for (int i = 0; i < CH_NUM; i++) deadline_q[i] <= '0;
      idx_q        <= '0;
      pend_q       <= 1'b0;
      exp_found_q  <= 1'b0;
      exp_ch_q     <= '0;
      min_found_q  <= 1'b0;
      min_ch_q     <= '0;
      min_rem_q    <= '0;
      fire_valid_q <= 1'b0;
      fire_ch_q    <= '0;
      next_valid_q <= 1'b0;
      next_ch_q    <= '0;
      next_rem_q   <= '0;
    end else begin
      state_q      <= state_d;
      now_q        <= now_d;
      active_q     <= active_d;
      deadline_q   <= deadline_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      exp_found_q  <= exp_found_d;
      exp_ch_q     <= exp_ch_d;
      min_found_q  <= min_found_d;
      min_ch_q     <= min_ch_d;
      min_rem_q    <= min_rem_d;
      fire_valid_q <= fire_valid_d;
      fire_ch_q    <= fire_ch_d;
      next_valid_q <= next_valid_d;
      next_ch_q    <= next_ch_d;
      next_rem_q   <= next_rem_d;
    end
  end

  assign req_ready_o  = (state_q == ST_IDLE) && !rst_i;
  assign now_o        = now_q;
  assign active_o     = active_q;
  assign fire_valid_o = fire_valid_q;
  assign fire_ch_o    = fire_ch_q;
  assign next_valid_o = next_valid_q;
  assign next_ch_o    = next_ch_q;
  assign next_rem_o   = next_rem_q;

endmodule
`default_nettype wire

// File: tb/tb_tmr_vtimer_sched.sv
`default_nettype none
// ============================================================================
// tb_tmr_vtimer_sched : randomized + directed bench with fire-event scoreboard
// Rev 1.0
// ============================================================================
module tb_tmr_vtimer_sched;

  localparam int CH_NUM   = 4;
  localparam int CH_IDX_W = 2;
  localparam int LAT      = 2 * CH_NUM + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, tick, req_valid, req_op, fire_ready, mon_hold;
  logic [CH_IDX_W-1:0] req_ch;
  logic [31:0]         req_delta;
  logic                req_ready_o, fire_valid_o, next_valid_o;
  logic [31:0]         now_o, next_rem_o;
  logic [CH_NUM-1:0]   active_o;
  logic [CH_IDX_W-1:0] fire_ch_o, next_ch_o;

  logic                tick8, req_valid8, req_op8, fire_ready8;
  logic [CH_IDX_W-1:0] req_ch8;
  logic [7:0]          req_delta8;
  logic                req_ready8, fire_valid8, next_valid8;
  logic [7:0]          now8, next_rem8;
  logic [CH_NUM-1:0]   active8;
  logic [CH_IDX_W-1:0] fire_ch8, next_ch8;

  tmr_vtimer_sched #(.CH_NUM(CH_NUM), .CNT_WIDTH(32)) u_dut (
    .clk_i(clk), .rst_i(rst), .tick_i(tick),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_op_i(req_op),
    .req_ch_i(req_ch), .req_delta_i(req_delta),
    .now_o(now_o), .active_o(active_o),
    .fire_valid_o(fire_valid_o), .fire_ch_o(fire_ch_o), .fire_ready_i(fire_ready),
    .next_valid_o(next_valid_o), .next_ch_o(next_ch_o), .next_rem_o(next_rem_o)
  );

  tmr_vtimer_sched #(.CH_NUM(CH_NUM), .CNT_WIDTH(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .tick_i(tick8),
    .req_valid_i(req_valid8), .req_ready_o(req_ready8), .req_op_i(req_op8),
    .req_ch_i(req_ch8), .req_delta_i(req_delta8),
    .now_o(now8), .active_o(active8),
    .fire_valid_o(fire_valid8), .fire_ch_o(fire_ch8), .fire_ready_i(fire_ready8),
    .next_valid_o(next_valid8), .next_ch_o(next_ch8), .next_rem_o(next_rem8)
  );

  // Reference model: absolute deadlines plus a queue of channels owed a fire event.
  logic [31:0]       m_now;
  logic [CH_NUM-1:0] m_act;
  logic [31:0]       m_dl [CH_NUM];
  int                exp_q [$];
  int                total = 0;
  int                bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  function automatic bit is_exp(input logic [31:0] rem);
    return (rem == 32'd0) || (rem >= 32'h8000_0000);
  endfunction

  task automatic m_reset();
    m_now = 32'd0;
    m_act = '0;
    for (int c = 0; c < CH_NUM; c++) m_dl[c] = 32'd0;
    exp_q.delete();
  endtask

  task automatic m_sweep();
    for (int c = 0; c < CH_NUM; c++)
      if (m_act[c] && is_exp(m_dl[c] - m_now)) begin
        exp_q.push_back(c);
        m_act[c] = 1'b0;
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    int n;
    n = 0;
    while (!req_ready_o && n < 200) begin step(); n++; end
    if (n >= 200) fail("settle");
    check("missed_fires", exp_q.size(), 0);
  endtask

  task automatic check_state();
    logic [31:0] best, rem;
    int          bc;
    bit          bv;
    bv = 1'b0; bc = 0; best = 32'd0;
    for (int c = 0; c < CH_NUM; c++)
      if (m_act[c]) begin
        rem = m_dl[c] - m_now;
        if (!is_exp(rem) && (!bv || rem < best)) begin
          bv = 1'b1; bc = c; best = rem;
        end
      end
    check("now", now_o, m_now);
    check("active", 32'(active_o), 32'(m_act));
    check("next_valid", 32'(next_valid_o), 32'(bv));
    if (bv) begin
      check("next_ch", 32'(next_ch_o), bc);
      check("next_rem", next_rem_o, best);
    end
  endtask

  task automatic do_req(input bit op, input int ch, input logic [31:0] delta);
    int n;
    n = 0;
    while (!req_ready_o && n < 200) begin step(); n++; end
    if (n >= 200) fail("req_ready");
    req_valid = 1'b1; req_op = op; req_ch = ch[CH_IDX_W-1:0]; req_delta = delta;
    if (!op) begin
      m_dl[ch]  = m_now + (delta[31] ? 32'h7FFF_FFFF : delta);
      m_act[ch] = 1'b1;
    end else begin
      m_act[ch] = 1'b0;
    end
    m_sweep();
    step();
    req_valid = 1'b0;
  endtask

  task automatic do_tick();
    int n;
    bit expect_fire;
    tick = 1'b1;
    step();
    tick = 1'b0;
    m_now = m_now + 32'd1;
    m_sweep();
    expect_fire = (exp_q.size() > 0);
    if (expect_fire) begin
      n = 0;
      while (!fire_valid_o && n < LAT) begin step(); n++; end
      check("fire_latency", 32'(fire_valid_o), 32'd1);
    end
  endtask

  // Scoreboard monitor: random backpressure, pops one expectation per handshake.
  initial begin : monitor
    logic                prev_v;
    logic [CH_IDX_W-1:0] prev_ch;
    int                  e;
    prev_v = 1'b0; prev_ch = '0; fire_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0; fire_ready = 1'b0;
        continue;
      end
      if (prev_v) begin
        check("fire_stable_v", 32'(fire_valid_o), 32'd1);
        check("fire_stable_ch", 32'(fire_ch_o), 32'(prev_ch));
      end
      fire_ready = mon_hold ? 1'b0 : ($urandom_range(0, 1) == 1);
      if (fire_valid_o && fire_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_fire_ch", 32'(fire_ch_o), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("fire_ch", 32'(fire_ch_o), e);
        end
        prev_v = 1'b0;
      end else begin
        prev_v  = fire_valid_o;
        prev_ch = fire_ch_o;
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int n, r;
    bit early;
    rst = 1'b1; tick = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_ch = '0; req_delta = '0;
    tick8 = 1'b0; req_valid8 = 1'b0; req_op8 = 1'b0; req_ch8 = '0; req_delta8 = '0;
    fire_ready8 = 1'b0; mon_hold = 1'b0;
    m_reset();
    repeat (3) step();
    rst = 1'b0;
    check("reset_now", now_o, 32'd0);
    check("reset_active", 32'(active_o), 32'd0);

    // Single arm, slow ticks, scheduled fire.
    do_req(1'b0, 2, 32'd5); settle(); check_state();
    check("t2_next_rem", next_rem_o, 32'd5);
    for (int k = 0; k < 5; k++) begin
      repeat (16) step();
      do_tick(); settle(); check_state();
    end

    // Equal deadlines with held backpressure: ch1 first, ch3 after.
    do_req(1'b0, 3, 32'd3); settle();
    do_req(1'b0, 1, 32'd3); settle(); check_state();
    do_tick(); settle();
    do_tick(); settle();
    mon_hold = 1'b1;
    do_tick();
    for (int k = 0; k < 10; k++) begin
      step();
      check("t3_hold_ch", 32'(fire_ch_o), 32'd1);
      check("t3_ready_low", 32'(req_ready_o), 32'd0);
    end
    mon_hold = 1'b0;
    settle(); check_state();

    // Cancel before deadline.
    rst = 1'b1; step(); rst = 1'b0; m_reset();
    do_req(1'b0, 0, 32'd20); settle();
    for (int k = 0; k < 10; k++) begin do_tick(); settle(); end
    do_req(1'b1, 0, 32'd0); settle(); check_state();
    for (int k = 0; k < 30; k++) begin do_tick(); settle(); end
    check_state();

    // Zero delta, saturating delta, reset abort of a pending fire.
    rst = 1'b1; step(); rst = 1'b0; m_reset();
    do_req(1'b0, 1, 32'd0); settle(); check_state();
    do_req(1'b0, 2, 32'h8000_0000); settle(); check_state();
    check("t6_sat_rem", next_rem_o, 32'h7FFF_FFFF);
    mon_hold = 1'b1;
    do_req(1'b0, 1, 32'd0);
    n = 0;
    while (!fire_valid_o && n < LAT) begin step(); n++; end
    check("t6_pending", 32'(fire_valid_o), 32'd1);
    rst = 1'b1;
    step();
    check("t6_abort", 32'(fire_valid_o), 32'd0);
    rst = 1'b0; m_reset(); mon_hold = 1'b0;

    // Randomized mix of arms, cancels and ticks.
    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 3)      do_req(1'b0, $urandom_range(0, CH_NUM-1), $urandom_range(0, 12));
      else if (r == 4) do_req(1'b0, $urandom_range(0, CH_NUM-1), $urandom_range(0, 40));
      else if (r == 5) do_req(1'b0, $urandom_range(0, CH_NUM-1), {1'b1, 31'($urandom)});
      else if (r == 6) do_req(1'b1, $urandom_range(0, CH_NUM-1), $urandom);
      else             do_tick();
      settle(); check_state();
    end

    // Reset held mid-operation.
    do_req(1'b0, 3, 32'd50); settle();
    rst = 1'b1;
    #1;
    check("rst_ready_low", 32'(req_ready_o), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_now", now_o, 32'd0);
      check("rst_active", 32'(active_o), 32'd0);
      check("rst_fire_valid", 32'(fire_valid_o), 32'd0);
      check("rst_next_valid", 32'(next_valid_o), 32'd0);
      check("rst_ready", 32'(req_ready_o), 32'd0);
    end
    rst = 1'b0; m_reset();
    #1;
    check("rst_release_ready", 32'(req_ready_o), 32'd1);

    // Timebase wrap on the 8-bit instance.
    tick8 = 1'b1; repeat (250) step(); tick8 = 1'b0;
    repeat (LAT + 2) step();
    check("w_now250", 32'(now8), 32'd250);
    n = 0;
    while (!req_ready8 && n < 50) begin step(); n++; end
    req_valid8 = 1'b1; req_op8 = 1'b0; req_ch8 = 2'd0; req_delta8 = 8'd10;
    step();
    req_valid8 = 1'b0;
    repeat (LAT + 2) step();
    check("w_armed_fire", 32'(fire_valid8), 32'd0);
    check("w_next_valid", 32'(next_valid8), 32'd1);
    check("w_next_ch", 32'(next_ch8), 32'd0);
    check("w_next_rem", 32'(next_rem8), 32'd10);
    for (int k = 0; k < 9; k++) begin
      tick8 = 1'b1; step(); tick8 = 1'b0;
      early = 1'b0;
      repeat (15) begin step(); if (fire_valid8) early = 1'b1; end
      check("w_no_early_fire", 32'(early), 32'd0);
    end
    check("w_now3", 32'(now8), 32'd3);
    tick8 = 1'b1; step(); tick8 = 1'b0;
    n = 0;
    while (!fire_valid8 && n < LAT) begin step(); n++; end
    check("w_fire", 32'(fire_valid8), 32'd1);
    check("w_fire_ch", 32'(fire_ch8), 32'd0);
    check("w_now4", 32'(now8), 32'd4);
    fire_ready8 = 1'b1; step(); fire_ready8 = 1'b0;
    repeat (LAT) step();
    check("w_active_clear", 32'(active8), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
